sys_ctrl: RTL and testbench
===========================

SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of the UART frame data, register-file data and ALU operands.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, the register-file address width.
REQ-003 SHALL have parameter ALU_FUN_WIDTH, default 4, the ALU function-code width.
REQ-004 SHALL have one clock and reset: CLK  in  1  single clock; RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have RX_P_DATA  in  DATA_WIDTH  received byte from UART RX.
REQ-006 SHALL have RX_D_VLD  in  1  one-cycle strobe qualifying RX_P_DATA.
REQ-007 SHALL have TX_P_DATA  out  DATA_WIDTH  byte for the UART TX FIFO.
REQ-008 SHALL have TX_D_VLD  out  1  one-cycle write strobe for the TX FIFO.
REQ-009 SHALL have FIFO_FULL  in  1  TX FIFO full; no TX_D_VLD is issued while it is high.
REQ-010 SHALL have ADDRESS  out  ADDR_WIDTH, WR_EN  out  1, RD_EN  out  1 and WR_DATA  out  DATA_WIDTH as the register-file port.
REQ-011 SHALL have RD_DATA  in  DATA_WIDTH and RD_DATA_VLD  in  1 as the register-file read return.
REQ-012 SHALL have ALU_EN  out  1, ALU_FUN  out  ALU_FUN_WIDTH, ALU_OUT  in  2*DATA_WIDTH and ALU_OUT_VLD  in  1 as the ALU port.
REQ-013 SHALL have CLK_GATE_EN  out  1, the enable for the ALU clock gate.

Function
REQ-014 SHALL decode the first byte of each command as 0xAA (RF write), 0xBB (RF read), 0xCC (ALU with operands) or 0xDD (ALU without operands), and ignore any other byte while in IDLE.
REQ-015 SHALL use the FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_BYTE, TX_LO and TX_HI; a state advances on a byte only when RX_D_VLD is high.
REQ-016 SHALL, for 0xAA, latch the next byte as the address (low ADDR_WIDTH bits), then on the data byte pulse WR_EN for exactly 1 cycle with ADDRESS and WR_DATA valid, and return to IDLE.
REQ-017 SHALL, for 0xBB, on the address byte pulse RD_EN for 1 cycle, wait in RD_WAIT for RD_DATA_VLD, latch RD_DATA, then send it from TX_BYTE.
REQ-018 SHALL, for 0xCC, write operand A to address 0 and operand B to address 1 (one WR_EN pulse each), then continue as 0xDD.
REQ-019 SHALL, for the function byte, assert CLK_GATE_EN and, one cycle later, pulse ALU_EN with ALU_FUN latched, wait in ALU_WAIT for ALU_OUT_VLD, then latch ALU_OUT.
REQ-020 SHALL hold CLK_GATE_EN high from function-byte acceptance through the ALU_OUT_VLD cycle, and low at all other times.
REQ-021 SHALL send the ALU result as the low byte (TX_LO) followed by the high byte (TX_HI).
REQ-022 SHALL, in every TX state, pulse TX_D_VLD for 1 cycle with TX_P_DATA stable only in a cycle where FIFO_FULL is low; otherwise it SHALL hold the state without a strobe.
REQ-023 SHALL ignore RX_D_VLD in RD_WAIT, ALU_WAIT and all TX states, dropping those bytes.
REQ-024 SHALL keep WR_EN, RD_EN, ALU_EN and TX_D_VLD as registered single-cycle pulses that are never asserted together.
REQ-025 SHALL, after the last TX strobe of a command, be in IDLE on the next cycle and able to accept a command byte in that cycle.

Reset
REQ-026 SHALL, on RST, go immediately to IDLE and force all outputs to 0, including TX_P_DATA, ADDRESS, WR_DATA and ALU_FUN.
REQ-027 SHALL, if reset occurs mid-command or mid-transmission, abandon that command with no further strobes after reset is released.

Structure
REQ-028 SHALL place the command opcodes, the FSM state encoding and the operand addresses (0, 1) in the shared system package.
REQ-029 SHALL be a single module with one FSM and registered outputs; no sub-module is needed.

Verification
REQ-030 SHALL be verified by: AA,05,3C -> one WR_EN pulse, ADDRESS=5, WR_DATA=0x3C, no TX strobe.
REQ-031 SHALL be verified by: BB,05, with RD_DATA=0x3C returned 2 cycles later -> RD_EN pulse, then one TX_D_VLD with TX_P_DATA=0x3C.
REQ-032 SHALL be verified by: CC,10,20,00, with ALU_OUT=0x0030 -> writes to addresses 0 and 1, ALU_EN with FUN=0, then TX 0x30 followed by 0x00.
REQ-033 SHALL be verified by: DD,02 with FIFO_FULL high for 5 cycles -> no strobe until FIFO_FULL falls, then both bytes sent in order with none lost.
REQ-034 SHALL be verified by: unknown byte 0x55, then AA,01,FF -> 0x55 ignored and the write completes normally.
REQ-035 SHALL be verified by: RST asserted in ALU_WAIT -> outputs are 0, CLK_GATE_EN is low, and no TX occurs after release.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: command opcodes, controller state encoding and ALU operand addresses.
package sys_ctrl_pkg;
  localparam logic [7:0] CMD_RF_WR = 8'hAA;
  localparam logic [7:0] CMD_RF_RD = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int OP_A_ADDR = 0;
  localparam int OP_B_ADDR = 1;
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT, ST_OP_A,
    ST_OP_B, ST_ALU_FUN_S, ST_ALU_WAIT, ST_TX_BYTE, ST_TX_LO, ST_TX_HI
  } state_t;
endpackage

// File: rtl/sys_ctrl.sv
// sys_ctrl: UART command decoder driving the register file, the ALU and the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  input  logic                      FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]     ADDRESS,
  output logic                      WR_EN,
  output logic                      RD_EN,
  output logic [DATA_WIDTH-1:0]     WR_DATA,
  input  logic [DATA_WIDTH-1:0]     RD_DATA,
  input  logic                      RD_DATA_VLD,
  output logic                      ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic                      CLK_GATE_EN
);
  state_t state, cmd_next;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic [2*DATA_WIDTH-1:0] alu_buf;
  logic alu_pend;
  always_comb
    cmd_next = (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))   ? ST_WR_ADDR :
               (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))   ? ST_RD_ADDR :
               (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  ? ST_OP_A :
               (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) ? ST_ALU_FUN_S : ST_IDLE;
  // alu_pend delays ALU_EN one cycle behind the clock-gate enable
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= ST_IDLE;
      TX_P_DATA <= '0;
      TX_D_VLD <= 1'b0;
      ADDRESS <= '0;
      WR_EN <= 1'b0;
      RD_EN <= 1'b0;
      WR_DATA <= '0;
      ALU_EN <= 1'b0;
      ALU_FUN <= '0;
      CLK_GATE_EN <= 1'b0;
      rd_buf <= '0;
      alu_buf <= '0;
      alu_pend <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      RD_EN <= 1'b0;
      ALU_EN <= 1'b0;
      TX_D_VLD <= 1'b0;
      case (state)
        ST_IDLE: if (RX_D_VLD) state <= cmd_next;
        ST_WR_ADDR: if (RX_D_VLD) begin
          ADDRESS <= RX_P_DATA[ADDR_WIDTH-1:0];
          state <= ST_WR_DATA;
        end
        ST_WR_DATA: if (RX_D_VLD) begin
          WR_DATA <= RX_P_DATA;
          WR_EN <= 1'b1;
          state <= ST_IDLE;
        end
        ST_RD_ADDR: if (RX_D_VLD) begin
          ADDRESS <= RX_P_DATA[ADDR_WIDTH-1:0];
          RD_EN <= 1'b1;
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: if (RD_DATA_VLD) begin
          rd_buf <= RD_DATA;
          state <= ST_TX_BYTE;
        end
        ST_OP_A: if (RX_D_VLD) begin
          ADDRESS <= ADDR_WIDTH'(OP_A_ADDR);
          WR_DATA <= RX_P_DATA;
          WR_EN <= 1'b1;
          state <= ST_OP_B;
        end
        ST_OP_B: if (RX_D_VLD) begin
          ADDRESS <= ADDR_WIDTH'(OP_B_ADDR);
          WR_DATA <= RX_P_DATA;
          WR_EN <= 1'b1;
          state <= ST_ALU_FUN_S;
        end
        ST_ALU_FUN_S: if (RX_D_VLD) begin
          ALU_FUN <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
          CLK_GATE_EN <= 1'b1;
          alu_pend <= 1'b1;
          state <= ST_ALU_WAIT;
        end
        ST_ALU_WAIT: if (alu_pend) begin
          ALU_EN <= 1'b1;
          alu_pend <= 1'b0;
        end else if (ALU_OUT_VLD) begin
          alu_buf <= ALU_OUT;
          CLK_GATE_EN <= 1'b0;
          state <= ST_TX_LO;
        end
        ST_TX_BYTE: if (!FIFO_FULL) begin
          TX_P_DATA <= rd_buf;
          TX_D_VLD <= 1'b1;
          state <= ST_IDLE;
        end
        ST_TX_LO: if (!FIFO_FULL) begin
          TX_P_DATA <= alu_buf[DATA_WIDTH-1:0];
          TX_D_VLD <= 1'b1;
          state <= ST_TX_HI;
        end
        ST_TX_HI: if (!FIFO_FULL) begin
          TX_P_DATA <= alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
          TX_D_VLD <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed command vectors against sys_ctrl with hand-computed results.
module tb_sys_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [DW-1:0] RX_P_DATA = '0;
  logic RX_D_VLD = 1'b0;
  logic [DW-1:0] TX_P_DATA;
  logic TX_D_VLD;
  logic FIFO_FULL = 1'b0;
  logic [AW-1:0] ADDRESS;
  logic WR_EN, RD_EN;
  logic [DW-1:0] WR_DATA;
  logic [DW-1:0] RD_DATA = '0;
  logic RD_DATA_VLD = 1'b0;
  logic ALU_EN;
  logic [FW-1:0] ALU_FUN;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic ALU_OUT_VLD = 1'b0;
  logic CLK_GATE_EN;
  logic [28:0] all_out;
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0] tx_q[$];
  int rd_cnt = 0, alu_cnt = 0, multi = 0, full_viol = 0;

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL),
    .ADDRESS(ADDRESS), .WR_EN(WR_EN), .RD_EN(RD_EN), .WR_DATA(WR_DATA),
    .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN)
  );

  always #5 CLK = ~CLK;
  assign all_out = {TX_P_DATA, TX_D_VLD, ADDRESS, WR_EN, RD_EN, WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN};

  always @(posedge CLK) begin
    #1;
    if (!RST) begin
      if (WR_EN) wr_q.push_back({ADDRESS, WR_DATA});
      if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
      if (TX_D_VLD && FIFO_FULL) full_viol++;
      if (RD_EN) rd_cnt++;
      if (ALU_EN) alu_cnt++;
      if ($countones({WR_EN, RD_EN, ALU_EN, TX_D_VLD}) > 1) multi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] txb(input int i);
    return (tx_q.size() > i) ? 32'(tx_q[i]) : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wrb(input int i);
    return (wr_q.size() > i) ? 32'(wr_q[i]) : 32'hxxxxxxxx;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 60 && tx_q.size() < n; i++) @(negedge CLK);
    chk("tx_count", tx_q.size(), n);
  endtask

  task automatic clear();
    wr_q.delete();
    tx_q.delete();
    rd_cnt = 0;
    alu_cnt = 0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_outs", 32'(all_out), 0);
    RST = 1'b0;
    // RF write
    clear();
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_en", WR_EN, 1);
    chk("wr_addr", ADDRESS, 5);
    chk("wr_data", WR_DATA, 'h3C);
    repeat (4) @(negedge CLK);
    chk("wr_once", wr_q.size(), 1);
    chk("wr_no_tx", tx_q.size(), 0);
    // RF read, with a stray byte dropped in RD_WAIT
    clear();
    send(8'hBB); send(8'h05);
    chk("rd_en", RD_EN, 1);
    chk("rd_addr", ADDRESS, 5);
    send(8'hAA);
    RD_DATA = 8'h3C;
    RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
    wait_tx(1);
    chk("rd_tx", txb(0), 'h3C);
    chk("rd_once", rd_cnt, 1);
    chk("rd_drop", wr_q.size(), 0);
    repeat (3) @(negedge CLK);
    // ALU with operands
    clear();
    send(8'hCC); send(8'h10); send(8'h20); send(8'h00);
    chk("gate_on", CLK_GATE_EN, 1);
    chk("alu_en_delay", ALU_EN, 0);
    @(negedge CLK);
    chk("alu_en", ALU_EN, 1);
    chk("alu_fun0", ALU_FUN, 0);
    ALU_OUT = 16'h0030;
    ALU_OUT_VLD = 1'b1;
    chk("gate_vld", CLK_GATE_EN, 1);
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    chk("gate_off", CLK_GATE_EN, 0);
    chk("op_a", wrb(0), 'h010);
    chk("op_b", wrb(1), 'h120);
    wait_tx(2);
    chk("alu_lo", txb(0), 'h30);
    chk("alu_hi", txb(1), 'h00);
    // next command byte accepted in the last strobe cycle
    chk("last_strobe", TX_D_VLD, 1);
    RX_P_DATA = 8'hAA;
    RX_D_VLD = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    send(8'h07); send(8'h99);
    chk("idle_accept", wrb(2), 'h799);
    // ALU without operands, FIFO full
    clear();
    FIFO_FULL = 1'b1;
    send(8'hDD); send(8'h02);
    @(negedge CLK);
    chk("alu_en2", ALU_EN, 1);
    chk("alu_fun2", ALU_FUN, 2);
    ALU_OUT = 16'hA55A;
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    repeat (5) @(negedge CLK);
    chk("full_hold", tx_q.size(), 0);
    FIFO_FULL = 1'b0;
    wait_tx(2);
    chk("full_lo", txb(0), 'h5A);
    chk("full_hi", txb(1), 'hA5);
    chk("full_viol", full_viol, 0);
    chk("dd_no_wr", wr_q.size(), 0);
    repeat (2) @(negedge CLK);
    // unknown byte ignored
    clear();
    send(8'h55); send(8'hAA); send(8'h01); send(8'hFF);
    chk("unk_wr_en", WR_EN, 1);
    repeat (2) @(negedge CLK);
    chk("unk_wr_cnt", wr_q.size(), 1);
    chk("unk_wr", wrb(0), 'h1FF);
    // reset in ALU_WAIT
    clear();
    send(8'hDD); send(8'h03);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_mid_outs", 32'(all_out), 0);
    @(negedge CLK);
    RST = 1'b0;
    ALU_OUT = 16'hBEEF;
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rst_no_tx", tx_q.size(), 0);
    chk("rst_idle_outs", 32'(all_out), 0);
    chk("no_overlap", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
